// File: rtl/mem_arbiter.sv
// Three-port arbiter (instruction fetch, load, store) in front of one
// single-port memory. Fixed priority st > ld > if, with a starvation guard
// for the fetch port and a bounded wait on the memory acknowledge.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mem_arbiter #(
  parameter int W       = `WORD_WIDTH,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_req,
  input  logic [W-1:0] if_addr,
  input  logic         ld_req,
  input  logic [W-1:0] ld_addr,
  input  logic         st_req,
  input  logic [W-1:0] st_addr,
  input  logic [W-1:0] st_data,
  output logic         if_done,
  output logic         ld_done,
  output logic         st_done,
  output logic [W-1:0] rdata,
  output logic         err,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  input  logic         mem_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_LD, OWN_ST} owner_t;

  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [2:0] STARVE_MAX = 3'd4;

  state_t       state, state_d;
  owner_t       owner, sel;
  logic         grant, finish, abort;
  logic [7:0]   tmo_cnt;
  logic [2:0]   starve_cnt;
  logic         starve_hit;

  assign starve_hit = (starve_cnt == STARVE_MAX);

  // State register; reset also abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state decode: grant selection in IDLE, ack/timeout resolution in BUSY.
  always_comb begin
    state_d = state;
    grant   = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    sel     = OWN_IF;
    case (state)
      IDLE: begin
        if (st_req || ld_req || if_req) begin
          grant   = 1'b1;
          state_d = BUSY;
          if (if_req && starve_hit) sel = OWN_IF;
          else if (st_req)          sel = OWN_ST;
          else if (ld_req)          sel = OWN_LD;
          else                      sel = OWN_IF;
        end
      end
      BUSY: begin
        // An ack on the last allowed cycle still counts as success.
        if (mem_ack) begin
          finish  = 1'b1;
          state_d = DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side request fields: latched on grant, held for the whole access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_req <= (state_d == BUSY);
      if (grant) begin
        owner     <= sel;
        mem_we    <= (sel == OWN_ST);
        mem_addr  <= (sel == OWN_ST) ? st_addr :
                     (sel == OWN_LD) ? ld_addr : if_addr;
        mem_wdata <= (sel == OWN_ST) ? st_data : '0;
      end
    end
  end

  // Completion pulses and read data; stores leave rdata untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_done <= 1'b0;
      ld_done <= 1'b0;
      st_done <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      if_done <= (finish || abort) && (owner == OWN_IF);
      ld_done <= (finish || abort) && (owner == OWN_LD);
      st_done <= (finish || abort) && (owner == OWN_ST);
      err     <= abort;
      if (owner != OWN_ST) begin
        if (finish)     rdata <= mem_rdata;
        else if (abort) rdata <= '0;
      end
    end
  end

  // Timeout counter: cleared on grant, counts BUSY cycles without ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         tmo_cnt <= '0;
    else if (grant)                  tmo_cnt <= '0;
    else if (abort)                  tmo_cnt <= tmo_cnt + 8'd1;
    else if (state == BUSY && !mem_ack) tmo_cnt <= tmo_cnt + 8'd1;
  end

  // Starvation counter: consecutive data grants taken while fetch was waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt <= '0;
    else if (grant) begin
      if (sel == OWN_IF)            starve_cnt <= '0;
      else if (!if_req)             starve_cnt <= '0;
      else if (!starve_hit)         starve_cnt <= starve_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with access/completion scoreboards and a
// behavioural memory whose ack delay is set per test.
module tb_mem_arbiter;

  localparam int W = 32;

  typedef struct {
    logic [1:0]  who;    // 0 = if, 1 = ld, 2 = st
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } item_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         if_req, ld_req, st_req;
  logic [W-1:0] if_addr, ld_addr, st_addr, st_data;
  logic         if_done, ld_done, st_done, err;
  logic [W-1:0] rdata;
  logic         mem_req, mem_we;
  logic [W-1:0] mem_addr, mem_wdata;
  logic [W-1:0] mem_rdata;
  logic         resp_ack, stray_ack;
  logic         mem_ack;

  assign mem_ack = resp_ack | stray_ack;

  int checks   = 0;
  int failures = 0;

  item_t acc_q[$];
  item_t done_q[$];

  int          ack_delay = 0;
  int          run       = 0;
  int          last_run  = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;
  logic [31:0] last_rd = '0;
  int          st_left = 0;
  int          st_n    = 0;

  mem_arbiter #(.W(W), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .ld_req(ld_req), .ld_addr(ld_addr),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
    .if_done(if_done), .ld_done(ld_done), .st_done(st_done),
    .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h40) ? 32'h2402_0005 : (a ^ 32'hA5A5_0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic item_t mk(input logic [1:0] who, input logic [31:0] addr,
                               input logic we, input logic [31:0] wdata,
                               input logic [31:0] rd, input logic e);
    item_t t;
    t.who = who; t.addr = addr; t.we = we; t.wdata = wdata; t.rdata = rd; t.err = e;
    return t;
  endfunction

  task automatic push(input item_t t);
    acc_q.push_back(t);
    done_q.push_back(t);
  endtask

  // Behavioural memory: checks each access against the scoreboard, acks after ack_delay.
  always @(negedge clk) begin
    if (mem_req) begin
      if (run == 0) begin
        cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
        if (acc_q.size() == 0) chk("unexpected_access", 32'd1, 32'd0);
        else begin
          item_t e;
          e = acc_q.pop_front();
          chk("access_addr", mem_addr, e.addr);
          chk("access_we", {31'd0, mem_we}, {31'd0, e.we});
          if (e.we) chk("access_wdata", mem_wdata, e.wdata);
        end
      end else begin
        chk("stable_addr", mem_addr, cap_addr);
        chk("stable_we", {31'd0, mem_we}, {31'd0, cap_we});
      end
      if (ack_delay >= 0 && run == ack_delay) begin
        resp_ack  = 1'b1;
        mem_rdata = mem_model(mem_addr);
      end else begin
        resp_ack  = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
      end
      run++;
    end else begin
      resp_ack = 1'b0;
      if (run != 0) last_run = run;
      run = 0;
    end
  end

  // Completion monitor: pops the done scoreboard and retires/reissues requests.
  always @(negedge clk) begin
    if (rst) last_rd = '0;
    else begin
      int n;
      n = int'(if_done) + int'(ld_done) + int'(st_done);
      if (n == 0) chk("err_without_done", {31'd0, err}, 32'd0);
      else begin
        chk("single_done", n, 1);
        if (done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          item_t e;
          logic [1:0] who;
          e = done_q.pop_front();
          who = st_done ? 2'd2 : (ld_done ? 2'd1 : 2'd0);
          chk("done_owner", {30'd0, who}, {30'd0, e.who});
          chk("done_err", {31'd0, err}, {31'd0, e.err});
          if (e.who == 2'd2) chk("store_keeps_rdata", rdata, last_rd);
          else begin
            chk("done_rdata", rdata, e.rdata);
            last_rd = e.rdata;
          end
        end
        if (if_done) if_req = 1'b0;
        if (ld_done) ld_req = 1'b0;
        if (st_done) begin
          if (st_left > 0) begin
            st_left--;
            st_n++;
            st_addr = 32'h1000 + 32'(st_n * 4);
            st_data = 32'hD000_0000 + 32'(st_n);
          end else st_req = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_q.size() == 0 && !mem_req) break;
    end
    chk("drain_within_budget", done_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; if_req = 0; ld_req = 0; st_req = 0;
    if_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0;
    stray_ack = 1'b0; resp_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done_err", {28'd0, if_done, ld_done, st_done, err}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fetch with ack in the first BUSY cycle: done on the third cycle.
    ack_delay = 0;
    push(mk(2'd0, 32'h40, 1'b0, '0, 32'h2402_0005, 1'b0));
    if_addr = 32'h40; if_req = 1'b1;
    @(negedge clk);
    chk("lat_busy_req", {31'd0, mem_req}, 1);
    chk("lat_no_early_done", {31'd0, if_done}, 0);
    @(negedge clk);
    chk("lat_if_done", {31'd0, if_done}, 1);
    chk("lat_rdata", rdata, 32'h2402_0005);
    chk("lat_err", {31'd0, err}, 0);
    wait_idle(20);

    // Stray ack while idle must be ignored.
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_ack_rdata", rdata, 32'h2402_0005);
    chk("stray_ack_no_req", {31'd0, mem_req}, 0);

    // All three at once: st, then ld, then if.
    push(mk(2'd2, 32'h300, 1'b1, 32'hCAFE_F00D, '0, 1'b0));
    push(mk(2'd1, 32'h100, 1'b0, '0, mem_model(32'h100), 1'b0));
    push(mk(2'd0, 32'h200, 1'b0, '0, mem_model(32'h200), 1'b0));
    st_left = 0; st_addr = 32'h300; st_data = 32'hCAFE_F00D; st_req = 1'b1;
    ld_addr = 32'h100; ld_req = 1'b1;
    if_addr = 32'h200; if_req = 1'b1;
    wait_idle(40);

    // Fetch held against back-to-back stores: fetch wins after four data grants.
    for (int k = 0; k < 4; k++)
      push(mk(2'd2, 32'h1000 + 32'(k * 4), 1'b1, 32'hD000_0000 + 32'(k), '0, 1'b0));
    push(mk(2'd0, 32'h500, 1'b0, '0, mem_model(32'h500), 1'b0));
    for (int k = 4; k < 6; k++)
      push(mk(2'd2, 32'h1000 + 32'(k * 4), 1'b1, 32'hD000_0000 + 32'(k), '0, 1'b0));
    push(mk(2'd1, 32'h600, 1'b0, '0, mem_model(32'h600), 1'b0));
    st_n = 0; st_left = 5; st_addr = 32'h1000; st_data = 32'hD000_0000; st_req = 1'b1;
    if_addr = 32'h500; if_req = 1'b1;
    ld_addr = 32'h600; ld_req = 1'b1;
    wait_idle(100);

    // Load that is never acked: 16 BUSY cycles, then done with err and rdata 0.
    ack_delay = -1;
    push(mk(2'd1, 32'h2000, 1'b0, '0, 32'h0, 1'b1));
    ld_addr = 32'h2000; ld_req = 1'b1;
    wait_idle(60);
    chk("timeout_req_cycles", last_run, 16);
    chk("timeout_rdata", rdata, 0);

    // Ack on the very cycle the timeout would fire: success, no err.
    ack_delay = 15;
    push(mk(2'd0, 32'h3000, 1'b0, '0, mem_model(32'h3000), 1'b0));
    if_addr = 32'h3000; if_req = 1'b1;
    wait_idle(60);
    chk("late_ack_req_cycles", last_run, 16);
    chk("late_ack_rdata", rdata, mem_model(32'h3000));

    // Reset during a store: access dropped at once, no st_done.
    ack_delay = -1;
    acc_q.push_back(mk(2'd2, 32'h4000, 1'b1, 32'h1234_5678, '0, 1'b0));
    st_left = 0; st_addr = 32'h4000; st_data = 32'h1234_5678; st_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", {31'd0, mem_req}, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_mem_req", {31'd0, mem_req}, 0);
    chk("rst_async_mem_addr", mem_addr, 0);
    chk("rst_async_no_done", {31'd0, st_done}, 0);
    st_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {31'd0, mem_req}, 0);
    ack_delay = 0;
    push(mk(2'd2, 32'h4004, 1'b1, 32'h8765_4321, '0, 1'b0));
    st_addr = 32'h4004; st_data = 32'h8765_4321; st_req = 1'b1;
    wait_idle(20);
    chk("acc_q_empty", acc_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
